// File: rtl/synth_reg_write_arbiter_pkg.sv
`default_nettype none
// ==== synth_reg_write_arbiter_pkg : synth register-port widths and write FSM states (rev 1.0) ====
package synth_reg_write_arbiter_pkg;

  localparam int SYN_ADDR_W = 4;
  localparam int SYN_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/synth_reg_write_arbiter_if.sv
`default_nettype none
// ==== synth_reg_write_arbiter_if : requester handshakes, synth write port, readback (rev 1.0) ====
interface synth_reg_write_arbiter_if;
  import synth_reg_write_arbiter_pkg::*;

  logic                  req0_valid_i;
  logic [SYN_ADDR_W-1:0] req0_addr_i;
  logic [SYN_DATA_W-1:0] req0_data_i;
  logic                  req0_ready_o;
  logic                  req1_valid_i;
  logic [SYN_ADDR_W-1:0] req1_addr_i;
  logic [SYN_DATA_W-1:0] req1_data_i;
  logic                  req1_ready_o;
  logic [SYN_ADDR_W-1:0] syn_addr_o;
  logic [SYN_DATA_W-1:0] syn_data_o;
  logic                  syn_strobe_o;
  logic                  busy_o;
  logic [SYN_ADDR_W-1:0] rd_addr_i;
  logic [SYN_DATA_W-1:0] rd_data_o;

  modport master (
    output req0_valid_i, req0_addr_i, req0_data_i,
    output req1_valid_i, req1_addr_i, req1_data_i,
    output rd_addr_i,
    input  req0_ready_o, req1_ready_o,
    input  syn_addr_o, syn_data_o, syn_strobe_o, busy_o, rd_data_o
  );

  modport slave (
    input  req0_valid_i, req0_addr_i, req0_data_i,
    input  req1_valid_i, req1_addr_i, req1_data_i,
    input  rd_addr_i,
    output req0_ready_o, req1_ready_o,
    output syn_addr_o, syn_data_o, syn_strobe_o, busy_o, rd_data_o
  );

endinterface
`default_nettype wire

// File: rtl/synth_reg_write_arbiter_rr_arbiter_2.sv
`default_nettype none
// ==== rr_arbiter_2 : two-way round-robin grant, pointer moves past the winner (rev 1.0) ====
module rr_arbiter_2 (
  input  wire logic       clk,
  input  wire logic       rst_n,
  input  wire logic [1:0] valid_i,
  input  wire logic       advance_i,
  output logic      [1:0] grant_o
);

  // pref_q selects the tie winner: 0 -> requester 0, 1 -> requester 1
  logic pref_q;

  always_comb begin
    grant_o = 2'b00;
    case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = pref_q ? 2'b10 : 2'b01;
      default: grant_o = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pref_q <= 1'b0;
    end else if (advance_i) begin
      pref_q <= grant_o[0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/synth_reg_write_arbiter.sv
`default_nettype none
// ==== synth_reg_write_arbiter : round-robin sharing of the synth register-write port with fixed
// ==== setup/strobe/gap timing; optional shadow readback via SYNTH_SHADOW_REGS_EN (rev 1.0) ====
module synth_reg_write_arbiter
  import synth_reg_write_arbiter_pkg::*;
#(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 1,
  parameter int GAP_CYCLES    = 8
) (
  input wire logic                 clk,
  input wire logic                 rst_n,
  synth_reg_write_arbiter_if.slave bus
);

  localparam int CNT_MAX = max3(SETUP_CYCLES, STROBE_CYCLES, GAP_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'((SETUP_CYCLES > 0) ? SETUP_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD    = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [SYN_ADDR_W-1:0] addr_q, addr_d;
  logic [SYN_DATA_W-1:0] data_q, data_d;
  logic                  strobe_q;

  logic [1:0] valid;
  logic [1:0] grant;
  logic [1:0] ready;
  logic       accept;
  logic       cnt_zero;

  assign valid  = {bus.req1_valid_i, bus.req0_valid_i};
  assign ready  = (rst_n && (state_q == ST_IDLE)) ? grant : 2'b00;
  assign accept = |(valid & ready);

  rr_arbiter_2 u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_i   (valid),
    .advance_i (accept),
    .grant_o   (grant)
  );

  assign cnt_zero = (cnt_q == '0);

  // Counter holds remaining cycles of the current state minus one; reloaded on every entry
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d = grant[1] ? bus.req1_addr_i : bus.req0_addr_i;
          data_d = grant[1] ? bus.req1_data_i : bus.req0_data_i;
          if (SETUP_CYCLES > 0) begin
            state_d = ST_SETUP;
            cnt_d   = SETUP_LD;
          end else begin
            state_d = ST_STROBE;
            cnt_d   = STROBE_LD;
          end
        end
      end
      ST_SETUP: begin
        if (cnt_zero) begin
          state_d = ST_STROBE;
          cnt_d   = STROBE_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_STROBE: begin
        if (cnt_zero) begin
          if (GAP_CYCLES > 0) begin
            state_d = ST_HOLD;
            cnt_d   = GAP_LD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt_zero) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      strobe_q <= (state_d == ST_STROBE);
    end
  end

  assign bus.req0_ready_o = ready[0];
  assign bus.req1_ready_o = ready[1];
  assign bus.syn_addr_o   = addr_q;
  assign bus.syn_data_o   = data_q;
  assign bus.syn_strobe_o = strobe_q;
  assign bus.busy_o       = (state_q != ST_IDLE);

`ifdef SYNTH_SHADOW_REGS_EN
  logic [SYN_DATA_W-1:0] shadow_q [16];
  logic                  shadow_we;

  // Write once, at the end of the first strobe cycle
  assign shadow_we = (state_q == ST_STROBE) && (cnt_q == STROBE_LD);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        shadow_q[i] <= '0;
      end
    end else if (shadow_we) begin
      shadow_q[addr_q] <= data_q;
    end
  end

  assign bus.rd_data_o = shadow_q[bus.rd_addr_i];
`else
  logic unused_rd_addr;
  assign unused_rd_addr = ^bus.rd_addr_i;
  assign bus.rd_data_o  = '0;
`endif

endmodule
`default_nettype wire
